// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matmul sequencer and its phase counter.
package matmul_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_READ    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    function automatic int row_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    function automatic int cnt_w(input int dim);
        return $clog2(3 * dim);
    endfunction

    function automatic int load_len(input int dim);
        return dim;
    endfunction

    // Feed DIM rows plus 2*(DIM-1) cycles to drain the input skew.
    function automatic int compute_len(input int dim);
        return 3 * dim - 2;
    endfunction

    function automatic int read_len(input int dim);
        return dim;
    endfunction

endpackage

// File: rtl/matmul_phase_cnt.sv
// Phase counter: clears or increments each cycle, flags the last cycle of a phase of length len.
module matmul_phase_cnt #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] cnt_d,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = clr ? '0 : cnt_q + CNT_W'(1);
        tc    = (cnt_q == len - CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequencer for one DIM x DIM multiply: load A, stream/drain B through the array, read C, pulse done.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter  int DIM   = 8,
    localparam int ROW_W = row_w(DIM),
    localparam int CNT_W = cnt_w(DIM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [ROW_W-1:0] src_row,
    output logic             a_wr_en,
    output logic [ROW_W-1:0] a_row,
    output logic             a_en,
    output logic             b_en,
    output logic             b_feed,
    output logic             sa_en,
    output logic             c_rd_en,
    output logic [ROW_W-1:0] c_row
);

    localparam logic [CNT_W-1:0] LOAD_LEN    = CNT_W'(load_len(DIM));
    localparam logic [CNT_W-1:0] COMPUTE_LEN = CNT_W'(compute_len(DIM));
    localparam logic [CNT_W-1:0] READ_LEN    = CNT_W'(read_len(DIM));

    state_t           state_q, state_d;
    logic             clr;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] cnt_d;
    logic             tc;

    logic             busy_d, done_d, a_wr_en_d, a_en_d, b_en_d, b_feed_d, sa_en_d, c_rd_en_d;
    logic [ROW_W-1:0] src_row_d, a_row_d, c_row_d;

    matmul_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .len   (len),
        .cnt_d (cnt_d),
        .tc    (tc)
    );

    always_comb begin
        state_d = state_q;
        clr     = 1'b1;
        len     = CNT_W'(1);
        case (state_q)
            S_IDLE:    if (start) state_d = S_LOAD;
            S_LOAD: begin
                len = LOAD_LEN;
                clr = tc;
                if (tc) state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                len = COMPUTE_LEN;
                clr = tc;
                if (tc) state_d = S_READ;
            end
            S_READ: begin
                len = READ_LEN;
                clr = tc;
                if (tc) state_d = S_DONE;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Abort outranks every terminal-count transition.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            clr     = 1'b1;
        end
    end

    // Outputs are decoded from the next state/count and registered alongside the state.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = 1'b0;
        a_wr_en_d = 1'b0;
        a_en_d    = 1'b0;
        b_en_d    = 1'b0;
        b_feed_d  = 1'b0;
        sa_en_d   = 1'b0;
        c_rd_en_d = 1'b0;
        src_row_d = '0;
        a_row_d   = '0;
        c_row_d   = '0;
        case (state_d)
            S_LOAD: begin
                a_wr_en_d = 1'b1;
                a_row_d   = cnt_d[ROW_W-1:0];
                src_row_d = cnt_d[ROW_W-1:0];
            end
            S_COMPUTE: begin
                a_en_d  = 1'b1;
                b_en_d  = 1'b1;
                sa_en_d = 1'b1;
                if (cnt_d < CNT_W'(DIM)) begin
                    b_feed_d  = 1'b1;
                    src_row_d = cnt_d[ROW_W-1:0];
                end
            end
            S_READ: begin
                c_rd_en_d = 1'b1;
                c_row_d   = cnt_d[ROW_W-1:0];
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            a_wr_en <= 1'b0;
            a_en    <= 1'b0;
            b_en    <= 1'b0;
            b_feed  <= 1'b0;
            sa_en   <= 1'b0;
            c_rd_en <= 1'b0;
            src_row <= '0;
            a_row   <= '0;
            c_row   <= '0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
            a_wr_en <= a_wr_en_d;
            a_en    <= a_en_d;
            b_en    <= b_en_d;
            b_feed  <= b_feed_d;
            sa_en   <= sa_en_d;
            c_rd_en <= c_rd_en_d;
            src_row <= src_row_d;
            a_row   <= a_row_d;
            c_row   <= c_row_d;
        end
    end

endmodule
